hv_bundle_encoder: RTL and testbench

Downstream consumer of the item-memory output FIFOs. It pops hypervectors from ports A and B and binds them by XOR; with the permute feature it also rotates the bound vector by its item index. Each bound vector is accumulated into per-bit saturating bundle counters. After a configured number of items, the counters are binarized and the result is presented as one encoded hypervector over a valid/ready handshake to the associative-memory stage.

---
 rtl/hv_encoder_pkg.sv | 28 ++
 rtl/hv_bundle_encoder_if.sv | 27 ++
 rtl/hv_bundler.sv | 52 +++++
 rtl/hv_bundle_encoder.sv | 190 +++++++++++++++++++
 tb/tb_hv_bundle_encoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_encoder_pkg.sv
// Shared types and constants for the hypervector bundle encoder: FSM states,
// bundle counter type and saturation limits derived from the counter width.
package hv_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_BINARIZE = 2'd2,
    ST_OUT      = 2'd3
  } state_e;

  localparam int unsigned BUNDLE_CNT_WIDTH = 8;

  typedef logic signed [BUNDLE_CNT_WIDTH-1:0] bundle_cnt_t;

  // Largest and smallest values a signed counter of the given width may hold
  function automatic int cnt_max(input int unsigned width);
    return (32'sd1 <<< (width - 32'd1)) - 32'sd1;
  endfunction

  function automatic int cnt_min(input int unsigned width);
    return -(32'sd1 <<< (width - 32'd1));
  endfunction

  localparam bundle_cnt_t BUNDLE_CNT_MAX = bundle_cnt_t'(cnt_max(BUNDLE_CNT_WIDTH));
  localparam bundle_cnt_t BUNDLE_CNT_MIN = bundle_cnt_t'(cnt_min(BUNDLE_CNT_WIDTH));

endpackage

// File: rtl/hv_bundle_encoder_if.sv
// Item-memory FIFO heads/pops and encoded-hypervector valid/ready bundle.
// master = encoder side, slave = item memory / associative-memory environment.
interface hv_bundle_encoder_if #(
  parameter int unsigned HVDimension = 512
) ();

  logic [HVDimension-1:0] im_a_i;
  logic                   im_a_valid_i;
  logic                   im_a_pop_o;
  logic [HVDimension-1:0] im_b_i;
  logic                   im_b_valid_i;
  logic                   im_b_pop_o;
  logic [HVDimension-1:0] hv_o;
  logic                   hv_valid_o;
  logic                   hv_ready_i;

  modport master (
    input  im_a_i, im_a_valid_i, im_b_i, im_b_valid_i, hv_ready_i,
    output im_a_pop_o, im_b_pop_o, hv_o, hv_valid_o
  );

  modport slave (
    output im_a_i, im_a_valid_i, im_b_i, im_b_valid_i, hv_ready_i,
    input  im_a_pop_o, im_b_pop_o, hv_o, hv_valid_o
  );

endinterface

// File: rtl/hv_bundler.sv
// Array of per-bit saturating signed bundle counters (+1 for a 1 bit, -1 for a 0 bit)
// with a combinational majority binarization (counter >= 0 gives 1).
module hv_bundler
  import hv_encoder_pkg::*;
#(
  parameter int unsigned HVDimension    = 512,
  parameter int unsigned BundleCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   acc_en_i,
  input  logic [HVDimension-1:0] item_i,
  output logic [HVDimension-1:0] hv_bin_o
);

  localparam logic signed [BundleCntWidth-1:0] CntMax = BundleCntWidth'(cnt_max(BundleCntWidth));
  localparam logic signed [BundleCntWidth-1:0] CntMin = BundleCntWidth'(cnt_min(BundleCntWidth));
  localparam logic signed [BundleCntWidth-1:0] CntOne = BundleCntWidth'(1);

  logic signed [BundleCntWidth-1:0] cnt_r [HVDimension];

  // Counter update: clear wins over accumulate; each bit saturates at its rail
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int unsigned i = 0; i < HVDimension; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (acc_en_i) begin
      for (int unsigned i = 0; i < HVDimension; i++) begin
        if (item_i[i]) begin
          if (cnt_r[i] != CntMax) begin
            cnt_r[i] <= cnt_r[i] + CntOne;
          end
        end else begin
          if (cnt_r[i] != CntMin) begin
            cnt_r[i] <= cnt_r[i] - CntOne;
          end
        end
      end
    end
  end

  // Binarization: a non-negative counter (sign bit clear) maps to 1, ties included
  always_comb begin
    hv_bin_o = '0;
    for (int unsigned i = 0; i < HVDimension; i++) begin
      hv_bin_o[i] = ~cnt_r[i][BundleCntWidth-1];
    end
  end

endmodule

// File: rtl/hv_bundle_encoder.sv
// Pops A/B item vectors, binds them by XOR, bundles them and emits one encoded vector.
// Optional feature macro HV_ENCODER_PERMUTE_EN: rotate the k-th item left by k bits.
module hv_bundle_encoder
  import hv_encoder_pkg::*;
#(
  parameter int unsigned HVDimension    = 512,
  parameter int unsigned BundleCntWidth = 8,
  parameter int unsigned ItemCntWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    start_i,
  input  logic                    cfg_bind_i,
  input  logic                    cfg_permute_i,
  input  logic [ItemCntWidth-1:0] cfg_num_items_i,
  output logic                    busy_o,
  output logic [ItemCntWidth-1:0] item_cnt_o,
  hv_bundle_encoder_if.master     bus
);

  state_e                  state_r;
  state_e                  state_s;
  logic                    bind_r;
  logic [ItemCntWidth-1:0] num_items_r;
  logic [ItemCntWidth-1:0] item_cnt_r;
  logic [HVDimension-1:0]  hv_r;
  logic                    hv_valid_r;
  logic                    accept_s;
  logic                    last_s;
  logic                    handshake_s;
  logic                    pop_a_s;
  logic                    pop_b_s;
  logic [HVDimension-1:0]  item_raw_s;
  logic [HVDimension-1:0]  item_s;
  logic [HVDimension-1:0]  hv_bin_s;

  // Accept only while running and enabled; in bind mode A never leaves without B
  assign accept_s    = rst_ni && en_i && (state_r == ST_ACCUM) && bus.im_a_valid_i &&
                       (bus.im_b_valid_i || !bind_r);
  assign last_s      = ((item_cnt_r + ItemCntWidth'(1)) == num_items_r);
  assign handshake_s = (state_r == ST_OUT) && bus.hv_ready_i;

  // Next-state and pop decode
  always_comb begin
    state_s = state_r;
    pop_a_s = 1'b0;
    pop_b_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_num_items_i == '0) begin
            state_s = ST_BINARIZE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          pop_a_s = 1'b1;
          pop_b_s = bind_r;
          if (last_s) begin
            state_s = ST_BINARIZE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_BINARIZE: begin
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (bus.hv_ready_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register; a dropped enable aborts any job
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job configuration captured on the accepted start cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      bind_r      <= 1'b0;
      num_items_r <= '0;
    end else if ((state_r == ST_IDLE) && start_i) begin
      bind_r      <= cfg_bind_i;
      num_items_r <= cfg_num_items_i;
    end
  end

  // Item counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i || handshake_s) begin
      item_cnt_r <= '0;
    end else if (accept_s) begin
      item_cnt_r <= item_cnt_r + ItemCntWidth'(1);
    end
  end

  // Output register: captured in BINARIZE, held through OUT until the handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      hv_r       <= '0;
      hv_valid_r <= 1'b0;
    end else if (state_r == ST_BINARIZE) begin
      hv_r       <= hv_bin_s;
      hv_valid_r <= 1'b1;
    end else if (handshake_s) begin
      hv_valid_r <= 1'b0;
    end
  end

`ifdef HV_ENCODER_PERMUTE_EN
  logic permute_r;

  function automatic logic [HVDimension-1:0] rotl(input logic [HVDimension-1:0] v,
                                                  input logic [31:0] amt);
    logic [2*HVDimension-1:0] dbl;
    dbl = {v, v} << amt;
    return dbl[2*HVDimension-1:HVDimension];
  endfunction

  // Permute enable captured with the rest of the job configuration
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      permute_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start_i) begin
      permute_r <= cfg_permute_i;
    end
  end

  // Bind then rotate by the 0-based item index modulo the vector width
  always_comb begin
    item_raw_s = bind_r ? (bus.im_a_i ^ bus.im_b_i) : bus.im_a_i;
    if (permute_r) begin
      item_s = rotl(item_raw_s, 32'(item_cnt_r) % HVDimension);
    end else begin
      item_s = item_raw_s;
    end
  end
`else
  logic unused_permute_s;
  assign unused_permute_s = cfg_permute_i;

  // Bind only; items accumulate unrotated
  always_comb begin
    item_raw_s = bind_r ? (bus.im_a_i ^ bus.im_b_i) : bus.im_a_i;
    item_s     = item_raw_s;
  end
`endif

  hv_bundler #(
    .HVDimension   (HVDimension),
    .BundleCntWidth(BundleCntWidth)
  ) u_bundler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (!en_i || handshake_s),
    .acc_en_i(accept_s),
    .item_i  (item_s),
    .hv_bin_o(hv_bin_s)
  );

  assign busy_o         = (state_r != ST_IDLE);
  assign item_cnt_o     = item_cnt_r;
  assign bus.im_a_pop_o = pop_a_s;
  assign bus.im_b_pop_o = pop_b_s;
  assign bus.hv_o       = hv_r;
  assign bus.hv_valid_o = hv_valid_r;

endmodule

// File: tb/tb_hv_bundle_encoder.sv
// Randomized bench for hv_bundle_encoder (HVDimension=8, BundleCntWidth=4) against a
// behavioural bundling model; honours HV_ENCODER_PERMUTE_EN like the design.
module tb_hv_bundle_encoder;

  localparam int D  = 8;
  localparam int W  = 4;
  localparam int IW = 16;
  localparam int CMAX = 7;
  localparam int CMIN = -8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          start;
  logic          cfg_bind;
  logic          cfg_perm;
  logic [IW-1:0] cfg_num;
  logic          busy;
  logic [IW-1:0] item_cnt;

  hv_bundle_encoder_if #(.HVDimension(D)) bus ();

  hv_bundle_encoder #(
    .HVDimension   (D),
    .BundleCntWidth(W),
    .ItemCntWidth  (IW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .start_i        (start),
    .cfg_bind_i     (cfg_bind),
    .cfg_permute_i  (cfg_perm),
    .cfg_num_items_i(cfg_num),
    .busy_o         (busy),
    .item_cnt_o     (item_cnt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [D-1:0] a_q[$];
  logic [D-1:0] b_q[$];
  int           model_cnt[D];
  logic [D-1:0] exp_hv;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D-1:0] rotl8(input logic [D-1:0] v, input int k);
    logic [D-1:0] r;
    r = v;
    for (int s = 0; s < k; s++) r = {r[D-2:0], r[D-1]};
    return r;
  endfunction

  // Reference: per-bit vote counts clamped to the counter range, majority with ties -> 1
  task automatic model_job(input bit bnd, input bit perm);
    logic [D-1:0] it;
    for (int i = 0; i < D; i++) model_cnt[i] = 0;
    for (int k = 0; k < a_q.size(); k++) begin
      it = bnd ? (a_q[k] ^ b_q[k]) : a_q[k];
`ifdef HV_ENCODER_PERMUTE_EN
      if (perm) it = rotl8(it, k % D);
`endif
      for (int i = 0; i < D; i++) begin
        if (it[i]) model_cnt[i] = (model_cnt[i] + 1 > CMAX) ? CMAX : model_cnt[i] + 1;
        else       model_cnt[i] = (model_cnt[i] - 1 < CMIN) ? CMIN : model_cnt[i] - 1;
      end
    end
    for (int i = 0; i < D; i++) exp_hv[i] = (model_cnt[i] >= 0);
  endtask

  function automatic int cnt0();
    return int'(dut.u_bundler.cnt_r[0]);
  endfunction

  // vmode 0: always valid, 1: random valids, 2: B held low for the first 4 cycles
  task automatic run_job(input bit bnd, input bit perm, input int vmode,
                         input int rdy_delay, input bit poke);
    int n;
    int idx;
    int cyc;
    bit pa;
    n   = a_q.size();
    idx = 0;
    cyc = 0;
    model_job(bnd, perm);
    cfg_bind = bnd;
    cfg_perm = perm;
    cfg_num  = IW'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cfg_bind = 1'($urandom);
    cfg_perm = 1'($urandom);
    cfg_num  = IW'($urandom);
    check_val("busy_after_start", 64'(busy), 64'd1);
    while (idx < n && cyc < 400) begin
      check_val("item_cnt_accum", 64'(item_cnt), 64'(idx));
      if (vmode == 0) begin
        bus.im_a_valid_i = 1'b1;
        bus.im_b_valid_i = 1'b1;
      end else if (vmode == 2 && cyc < 4) begin
        bus.im_a_valid_i = 1'b1;
        bus.im_b_valid_i = 1'b0;
      end else begin
        bus.im_a_valid_i = 1'($urandom_range(0, 1));
        bus.im_b_valid_i = 1'($urandom_range(0, 1));
      end
      bus.im_a_i = a_q[idx];
      bus.im_b_i = bnd ? b_q[idx] : D'($urandom);
      #1;
      pa = bus.im_a_valid_i && (bus.im_b_valid_i || !bnd);
      check_val("pop_a", 64'(bus.im_a_pop_o), 64'(pa));
      check_val("pop_b", 64'(bus.im_b_pop_o), 64'(pa && bnd));
      if (pa) idx++;
      @(negedge clk);
      cyc++;
    end
    if (idx < n) check_val("accum_timeout", 64'(idx), 64'(n));
    bus.im_a_valid_i = 1'b0;
    bus.im_b_valid_i = 1'b0;
    check_val("binarize_valid_low", 64'(bus.hv_valid_o), 64'd0);
    check_val("binarize_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check_val("out_valid", 64'(bus.hv_valid_o), 64'd1);
    check_val("out_hv", 64'(bus.hv_o), 64'(exp_hv));
    check_val("out_item_cnt", 64'(item_cnt), 64'(n));
    check_val("out_cnt0", 64'(cnt0()), 64'(model_cnt[0]));
    for (int r = 0; r < rdy_delay; r++) begin
      bus.im_a_valid_i = 1'b1;
      bus.im_b_valid_i = 1'b1;
      if (poke) begin
        start   = 1'b1;
        cfg_num = '0;
      end
      #1;
      check_val("hold_pop_a", 64'(bus.im_a_pop_o), 64'd0);
      check_val("hold_pop_b", 64'(bus.im_b_pop_o), 64'd0);
      @(negedge clk);
      start = 1'b0;
      check_val("hold_hv", 64'(bus.hv_o), 64'(exp_hv));
      check_val("hold_valid", 64'(bus.hv_valid_o), 64'd1);
    end
    bus.im_a_valid_i = 1'b0;
    bus.im_b_valid_i = 1'b0;
    bus.hv_ready_i   = 1'b1;
    @(negedge clk);
    bus.hv_ready_i   = 1'b0;
    check_val("post_hs_valid", 64'(bus.hv_valid_o), 64'd0);
    check_val("post_hs_busy", 64'(busy), 64'd0);
    check_val("post_hs_item_cnt", 64'(item_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0;
    cfg_bind = 1'b0; cfg_perm = 1'b0; cfg_num = '0;
    bus.im_a_i = '0; bus.im_b_i = '0;
    bus.im_a_valid_i = 1'b1; bus.im_b_valid_i = 1'b1; bus.hv_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_item_cnt", 64'(item_cnt), 64'd0);
    check_val("rst_hv", 64'(bus.hv_o), 64'd0);
    check_val("rst_hv_valid", 64'(bus.hv_valid_o), 64'd0);
    check_val("rst_pop_a", 64'(bus.im_a_pop_o), 64'd0);
    check_val("rst_pop_b", 64'(bus.im_b_pop_o), 64'd0);
    bus.im_a_valid_i = 1'b0; bus.im_b_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Bind, three items 0xFF, 0x0F, 0x00
    a_q = '{8'hFF, 8'hF0, 8'hAA}; b_q = '{8'h00, 8'hFF, 8'hAA};
    run_job(1'b1, 1'b0, 0, 0, 1'b0);
    // Bind with B starved for four cycles
    a_q = '{8'h3C, 8'h81, 8'h7E}; b_q = '{8'h11, 8'hC3, 8'h5A};
    run_job(1'b1, 1'b0, 2, 0, 1'b0);
    // Saturation: 12 x 0xFF then 0x00
    a_q.delete(); b_q.delete();
    for (int k = 0; k < 12; k++) begin a_q.push_back(8'hFF); b_q.push_back(8'h00); end
    a_q.push_back(8'h00); b_q.push_back(8'h00);
    run_job(1'b0, 1'b0, 0, 0, 1'b0);
    // Zero-item job
    a_q.delete(); b_q.delete();
    run_job(1'b0, 1'b0, 0, 0, 1'b0);
    // Tie
    a_q = '{8'hF0, 8'h0F}; b_q = '{8'h00, 8'h00};
    run_job(1'b0, 1'b0, 0, 0, 1'b0);
    // Permute request
    a_q = '{8'h01, 8'h01}; b_q = '{8'h00, 8'h00};
    run_job(1'b0, 1'b1, 0, 0, 1'b0);
    // Ready held low five cycles with a stray start
    a_q = '{8'h96, 8'h69, 8'hF3}; b_q = '{8'h0F, 8'hF0, 8'h33};
    run_job(1'b1, 1'b0, 0, 5, 1'b1);

    // Abort mid-ACCUM after two items
    cfg_bind = 1'b0; cfg_perm = 1'b0; cfg_num = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.im_a_i = 8'hFF; bus.im_a_valid_i = 1'b1;
      #1;
      check_val("abort_pop_a", 64'(bus.im_a_pop_o), 64'd1);
      @(negedge clk);
    end
    en = 1'b0;
    #1;
    check_val("abort_pop_forced", 64'(bus.im_a_pop_o), 64'd0);
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_item_cnt", 64'(item_cnt), 64'd0);
    check_val("abort_hv_valid", 64'(bus.hv_valid_o), 64'd0);
    en = 1'b1; bus.im_a_valid_i = 1'b0;
    @(negedge clk);
    a_q = '{8'h00}; b_q = '{8'h00};
    run_job(1'b0, 1'b0, 0, 0, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 15; j++) begin
      int n;
      n = $urandom_range(1, 20);
      a_q.delete(); b_q.delete();
      for (int k = 0; k < n; k++) begin
        a_q.push_back(D'($urandom));
        b_q.push_back(D'($urandom));
      end
      run_job(1'($urandom), 1'($urandom), 1, $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
